// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the default queue geometry, the default-geometry entry type and the
// pointer-width helper used by the queue and the top level.
package wb_pkg;

  localparam int WB_DEPTH_DEFAULT  = 4;
  localparam int WB_DATA_W_DEFAULT = 4;
  localparam int WB_ADDR_W_DEFAULT = 5;

  // Pointer width for the default depth; pointers wrap naturally at depth.
  localparam int WB_PTR_W_DEFAULT = (WB_DEPTH_DEFAULT <= 1) ? 1 : $clog2(WB_DEPTH_DEFAULT);

  // One queued write-back: destination register and result value.
  typedef struct packed {
    logic [WB_ADDR_W_DEFAULT-1:0] addr;
    logic [WB_DATA_W_DEFAULT-1:0] data;
  } wb_entry_t;

  // Pointer width for an arbitrary power-of-two depth.
  function automatic int wb_ptr_w(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue: storage, head/tail pointers and occupancy count.
// Every slot and its valid bit are exposed so the top level can search the
// queued writes for forwarding. Flush empties the queue and drops any push.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int AW    = 5,
  parameter  int DW    = 4,
  parameter  int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PTRW  = wb_ptr_w(DEPTH),
  localparam int PW    = $clog2(DEPTH + 1),
  localparam int EW    = AW + DW
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [EW-1:0]             wr_entry_i,
  output logic [EW-1:0]             head_entry_o,
  output logic [PW-1:0]             count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [PTRW-1:0]           head_ptr_o,
  output logic [DEPTH-1:0][EW-1:0]  entries_o,
  output logic [DEPTH-1:0]          valid_o
);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [PW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == PW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full queue ignores pushes; flush overrides both push and pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointers and count; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTRW'(1);
      if (do_pop)  head_d = head_q + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots are only observed through their valid bits.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= wr_entry_i;
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    logic [PTRW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTRW'(i) - head_q;
      entries_o[i] = mem_q[i];
      valid_o[i]   = (PW'(off) < count_q);
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign count_o      = count_q;
  assign head_ptr_o   = head_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write initiator: queues write-backs in order and issues at
// most one registered write per cycle. Stall holds the head, flush discards
// everything. Build with WB_FORWARD_EN to get the forwarding lookup; without
// it fwd_hit/fwd_data are tied to 0 and fwd_reg is ignored.
module writeback_unit
  import wb_pkg::*;
#(
  parameter  int dataWidth = 4,
  parameter  int addWidth  = 5,
  parameter  int depth     = WB_DEPTH_DEFAULT,
  localparam int PW        = $clog2(depth + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [addWidth-1:0]  in_reg,
  input  logic [dataWidth-1:0] in_data,
  input  logic                 wb_stall,
  input  logic                 flush,
  output logic                 reg_write,
  output logic [addWidth-1:0]  write_register,
  output logic [dataWidth-1:0] write_data,
  output logic [PW-1:0]        pending,
  input  logic [addWidth-1:0]  fwd_reg,
  output logic                 fwd_hit,
  output logic [dataWidth-1:0] fwd_data
);

  localparam int EW   = addWidth + dataWidth;
  localparam int PTRW = wb_ptr_w(depth);

  // Handshake: a write-back transfers on an edge where in_valid and in_ready
  // are both 1. in_ready depends only on registered occupancy, never on
  // in_valid; the producer may hold in_valid while in_ready is 0.

  logic                      full, empty, pop;
  logic [PW-1:0]             count;
  logic [EW-1:0]             head_entry;
  logic [PTRW-1:0]           head_ptr;
  logic [depth-1:0][EW-1:0]  entries;
  logic [depth-1:0]          valid;

  logic                 reg_write_q, reg_write_d;
  logic [addWidth-1:0]  wr_reg_q, wr_reg_d;
  logic [dataWidth-1:0] wr_data_q, wr_data_d;

  assign pop = !flush && !wb_stall && !empty;

  wb_fifo #(
    .AW    (addWidth),
    .DW    (dataWidth),
    .DEPTH (depth)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush_i      (flush),
    .push_i       (in_valid),
    .pop_i        (pop),
    .wr_entry_i   ({in_reg, in_data}),
    .head_entry_o (head_entry),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .head_ptr_o   (head_ptr),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  assign in_ready = !full;
  assign pending  = count;

  // Output stage: load the head on issue, otherwise drop the enable and hold.
  always_comb begin
    reg_write_d = pop;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (pop) {wr_reg_d, wr_data_d} = head_entry;
  end

  // Output stage registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign write_register = wr_reg_q;
  assign write_data     = wr_data_q;

`ifdef WB_FORWARD_EN
  logic [PTRW-1:0] slot;

  // Forwarding search: output stage first, then queue oldest to youngest so
  // the youngest matching write wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    if (reg_write_q && (wr_reg_q == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data_q;
    end
    for (int k = 0; k < depth; k++) begin
      slot = head_ptr + PTRW'(k);
      if (valid[slot] && (entries[slot][EW-1 -: addWidth] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[slot][dataWidth-1:0];
      end
    end
  end
`else
  logic unused_fwd;

  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  assign unused_fwd = ^{fwd_reg, head_ptr, entries, valid};
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, hand-written corner
// sequences (reset mid-drain, back-to-back stream) and a randomized run, all
// checked against a queue-based reference model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int EW    = AW + DW;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          wb_stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] in_reg = '0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] fwd_reg = '0;
  logic          in_ready, reg_write, fwd_hit;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data, fwd_data;
  logic [PW-1:0] pending;

  always #5 clock = ~clock;

  writeback_unit #(.dataWidth(DW), .addWidth(AW), .depth(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_reg         (in_reg),
    .in_data        (in_data),
    .wb_stall       (wb_stall),
    .flush          (flush),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .pending        (pending),
    .fwd_reg        (fwd_reg),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];   // queued writes, oldest first
  logic          m_rw;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  // One clock edge of the behavioural model.
  task automatic model_edge(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                            input logic s, input logic f);
    logic can_push;
    can_push = (exp_q.size() < DEPTH);
    if (f) begin
      exp_q.delete();
      m_rw = 1'b0;
    end else begin
      if (!s && exp_q.size() > 0) begin
        {m_wr, m_wd} = exp_q.pop_front();
        m_rw = 1'b1;
      end else begin
        m_rw = 1'b0;
      end
      if (v && can_push) exp_q.push_back({r, d});
    end
  endtask

  task automatic model_fwd(input logic [AW-1:0] r, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
`ifdef WB_FORWARD_EN
    if (m_rw && m_wr == r) begin
      h = 1'b1;
      d = m_wd;
    end
    foreach (exp_q[i]) begin
      if (exp_q[i][EW-1:DW] == r) begin
        h = 1'b1;
        d = exp_q[i][DW-1:0];
      end
    end
`endif
  endtask

  task automatic check_model(input string tag);
    logic          h;
    logic [DW-1:0] d;
    model_fwd(fwd_reg, h, d);
    check({tag, "_reg_write"}, 32'(reg_write), 32'(m_rw));
    check({tag, "_write_register"}, 32'(write_register), 32'(m_wr));
    check({tag, "_write_data"}, 32'(write_data), 32'(m_wd));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_q.size() < DEPTH));
    check({tag, "_pending"}, 32'(pending), 32'(exp_q.size()));
    check({tag, "_fwd_hit"}, 32'(fwd_hit), 32'(h));
    check({tag, "_fwd_data"}, 32'(fwd_data), 32'(d));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                      input logic s, input logic f, input logic [AW-1:0] fr, input string tag);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    wb_stall = s;
    flush    = f;
    fwd_reg  = fr;
    @(posedge clock);
    model_edge(v, r, d, s, f);
    #1;
    check_model(tag);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    wb_stall = 1'b0;
    flush    = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic          s;
    logic          f;
    logic [AW-1:0] fr;
    logic          rw;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic          rdy;
    logic [PW-1:0] pend;
    logic          hit;
    logic [DW-1:0] fd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int v, r, d, s, f, fr, rw, wr, wd, rdy, pend, hit, fd);
    vec_t t;
    t.v = 1'(v);   t.r = AW'(r);   t.d = DW'(d);   t.s = 1'(s);   t.f = 1'(f);
    t.fr = AW'(fr); t.rw = 1'(rw); t.wr = AW'(wr); t.wd = DW'(wd);
    t.rdy = 1'(rdy); t.pend = PW'(pend); t.hit = 1'(hit); t.fd = DW'(fd);
    return t;
  endfunction

  initial begin
    //                v  r  d   s  f  fr   rw wr wd  rdy pend hit fd
    // basic latency
    vecs.push_back(mk(1, 5, 10, 0, 0, 0,   0, 0, 0,  1, 1,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   1, 5, 10, 1, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   0, 5, 10, 1, 0,  0, 0));
    // full with stall, then release
    vecs.push_back(mk(1, 1, 1,  1, 0, 0,   0, 5, 10, 1, 1,  0, 0));
    vecs.push_back(mk(1, 2, 2,  1, 0, 0,   0, 5, 10, 1, 2,  0, 0));
    vecs.push_back(mk(1, 3, 3,  1, 0, 0,   0, 5, 10, 1, 3,  0, 0));
    vecs.push_back(mk(1, 4, 4,  1, 0, 0,   0, 5, 10, 0, 4,  0, 0));
    vecs.push_back(mk(1, 9, 15, 1, 0, 0,   0, 5, 10, 0, 4,  0, 0));
    vecs.push_back(mk(1, 9, 15, 0, 0, 0,   1, 1, 1,  1, 3,  0, 0));
    vecs.push_back(mk(1, 9, 15, 0, 0, 0,   1, 2, 2,  1, 3,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   1, 3, 3,  1, 2,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   1, 4, 4,  1, 1,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   1, 9, 15, 1, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   0, 9, 15, 1, 0,  0, 0));
    // flush priority over a same-cycle push
    vecs.push_back(mk(1, 6, 6,  1, 0, 0,   0, 9, 15, 1, 1,  0, 0));
    vecs.push_back(mk(1, 7, 7,  1, 0, 0,   0, 9, 15, 1, 2,  0, 0));
    vecs.push_back(mk(1, 8, 8,  0, 1, 0,   0, 9, 15, 1, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   0, 9, 15, 1, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,   0, 9, 15, 1, 0,  0, 0));
    // forwarding: youngest queued write wins, output stage searched too
    vecs.push_back(mk(1, 3, 2,  1, 0, 3,   0, 9, 15, 1, 1,  1, 2));
    vecs.push_back(mk(1, 3, 7,  1, 0, 3,   0, 9, 15, 1, 2,  1, 7));
    vecs.push_back(mk(0, 0, 0,  1, 0, 4,   0, 9, 15, 1, 2,  0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 3,   1, 3, 2,  1, 1,  1, 7));
    vecs.push_back(mk(0, 0, 0,  0, 0, 3,   1, 3, 7,  1, 0,  1, 7));
    vecs.push_back(mk(0, 0, 0,  0, 0, 3,   0, 3, 7,  1, 0,  0, 0));
  end

  // ---------------- test sequence ----------------
  initial begin
    logic v, s, f;
    apply_reset();
    #1;
    check("reset_reg_write", 32'(reg_write), 32'd0);
    check("reset_write_register", 32'(write_register), 32'd0);
    check("reset_write_data", 32'(write_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_fwd_hit", 32'(fwd_hit), 32'd0);
    check("reset_fwd_data", 32'(fwd_data), 32'd0);

    // Directed table.
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].f, vecs[i].fr,
           $sformatf("vec%0d_model", i));
      check($sformatf("vec%0d_reg_write", i), 32'(reg_write), 32'(vecs[i].rw));
      check($sformatf("vec%0d_write_register", i), 32'(write_register), 32'(vecs[i].wr));
      check($sformatf("vec%0d_write_data", i), 32'(write_data), 32'(vecs[i].wd));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
`ifdef WB_FORWARD_EN
      check($sformatf("vec%0d_fwd_hit", i), 32'(fwd_hit), 32'(vecs[i].hit));
      check($sformatf("vec%0d_fwd_data", i), 32'(fwd_data), 32'(vecs[i].fd));
`else
      check($sformatf("vec%0d_fwd_hit", i), 32'(fwd_hit), 32'd0);
      check($sformatf("vec%0d_fwd_data", i), 32'(fwd_data), 32'd0);
`endif
    end

    // Back-to-back stream of 10 with no stall: occupancy settles at 1.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, AW'(16 + i), DW'(i), 1'b0, 1'b0, AW'(16 + i), $sformatf("stream%0d", i));
      check($sformatf("stream%0d_pending_one", i), 32'(pending), 32'd1);
      if (i > 0) check($sformatf("stream%0d_issue", i), 32'(write_register), 32'(16 + i - 1));
    end
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, "stream_drain0");
    check("stream_last_issue", 32'(write_register), 32'd25);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, "stream_drain1");

    // Reset mid-drain: three queued, one issued, reset before the second issue.
    step(1'b1, AW'(10), DW'(1), 1'b1, 1'b0, AW'(10), "rst_fill0");
    step(1'b1, AW'(11), DW'(2), 1'b1, 1'b0, AW'(10), "rst_fill1");
    step(1'b1, AW'(12), DW'(3), 1'b1, 1'b0, AW'(10), "rst_fill2");
    step(1'b0, '0, '0, 1'b0, 1'b0, AW'(10), "rst_issue0");
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_reg_write", 32'(reg_write), 32'd0);
    check("rst_mid_write_register", 32'(write_register), 32'd0);
    check("rst_mid_write_data", 32'(write_data), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_pending", 32'(pending), 32'd0);
    check("rst_mid_fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst_mid_fwd_data", 32'(fwd_data), 32'd0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, AW'(11), $sformatf("rst_after%0d", i));
      check($sformatf("rst_after%0d_no_issue", i), 32'(reg_write), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 39) == 0);
      step(v, AW'($urandom_range(0, 7)), DW'($urandom), s, f, AW'($urandom_range(0, 7)),
           $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side initiator for the CPU register file: accepts result write-backs from the execute/memory stages through a valid/ready handshake, buffers them in an in-order queue, and issues at most one write per cycle on the register file's `reg_write` / `write_register` / `write_data` port. Optionally provides a forwarding lookup so decode can read results that are still queued.

## Interface
- `dataWidth`, 4: width of the register data word.
- `addWidth`, 5: width of the register address.
- `depth`, 4: queue entries; power of two, 2..16.

Ports (`PW` = clog2(`depth`+1)):
- `clock` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer has a write-back.
- `in_ready` output 1: queue can accept (registered; equals `count < depth`).
- `in_reg` input `addWidth`: destination register.
- `in_data` input `dataWidth`: result value.
- `wb_stall` input 1: blocks issue to the register file this cycle.
- `flush` input 1: synchronous discard of all queued and issuing writes.
- `reg_write` output 1: register file write enable (registered).
- `write_register` output `addWidth`: register file write address (registered).
- `write_data` output `dataWidth`: register file write data (registered).
- `pending` output `PW`: number of queued entries, excluding the output stage.
- `fwd_reg` input `addWidth`: forwarding lookup address.
- `fwd_hit` output 1: a pending write targets `fwd_reg`.
- `fwd_data` output `dataWidth`: value of the youngest such write.

## Operation
- Push: `in_valid && in_ready` at an edge writes {`in_reg`, `in_data`} at the tail.
- Issue: at each edge where `!flush`, `!wb_stall` and `count > 0`:
  - the head is popped into the output registers;
  - `reg_write` is set to 1.
- Otherwise `reg_write` is set to 0, and `write_register` / `write_data` hold their previous values.
- Ordering: strictly FIFO; duplicate destinations are all issued in arrival order.
- Simultaneous push and pop: `count` is unchanged; the head and tail pointers both advance modulo `depth`.
- Full: `in_ready` is 0 and `in_valid` is ignored. There is no same-cycle bypass when full.
- Empty: no pop. `reg_write` is 0 the next cycle.
- Flush has priority over push and issue:
  - `count` goes to 0 and both pointers go to 0;
  - `reg_write` goes to 0;
  - a push in the same cycle is dropped.
- Reset (`reset_n` low, at any time, including mid-drain):
  - `count`, pointers, `reg_write`, `write_register` and `write_data` all go to 0;
  - `in_ready` goes to 1;
  - `pending` goes to 0;
  - `fwd_hit` and `fwd_data` go to 0.
- Pointers are `clog2(depth)` bits wide and wrap naturally. `count` is `PW` bits and saturates logically at `depth`.

## Timing
- A push accepted at edge N into an empty queue appears on `reg_write` / `write_register` / `write_data` after edge N+1. The register file captures it at edge N+2.
- Sustained throughput is one write per cycle while `wb_stall` is 0.
- `wb_stall` sampled high at edge N yields `reg_write` = 0 for cycle N..N+1; the head is retained.
- `in_ready` and `pending` reflect the state after the last edge. They are never combinational from `in_valid`.
- `fwd_hit` / `fwd_data` are combinational from `fwd_reg` and the current state.
- The lookup searches the output stage (when `reg_write` = 1) plus all queued entries. Priority runs from youngest queue entry, to oldest, to output stage.

## Configuration
- `WB_FORWARD_EN` defined:
  - the forwarding comparators and priority mux are built;
  - `fwd_hit` / `fwd_data` behave as described under Timing.
- `WB_FORWARD_EN` undefined:
  - no comparators are built;
  - `fwd_hit` is tied 0 and `fwd_data` is tied 0;
  - `fwd_reg` is ignored;
  - the port list is unchanged.

## Structure
- Shared package `wb_pkg`:
  - entry typedef {reg address, data};
  - `WB_DEPTH_DEFAULT` constant;
  - pointer-width helper constant.
- Sub-module `wb_fifo`:
  - storage array, head/tail pointers, count, full/empty;
  - exposes all entries and valid bits for the forwarding search.
- The top level `writeback_unit` owns the output stage, flush/stall control and the forwarding mux.

## Test plan
- Reset mid-drain:
  - stimulus: push 3 entries, then drop `reset_n` before the second issue;
  - required: all outputs are 0, `in_ready` = 1, and nothing is issued after reset release.
- Basic latency:
  - stimulus: push {r5, 0xA} at edge 1 into an empty queue;
  - required: after edge 2, `reg_write` = 1, `write_register` = 5, `write_data` = 0xA; after edge 3, `reg_write` = 0.
- Full with stall:
  - stimulus: `wb_stall` = 1, push 4 entries (r1..r4, 0x1..0x4), then keep `in_valid` = 1 with {r9, 0xF};
  - required: `in_ready` = 0 and `pending` = 4; after releasing the stall, r1..r4 issue on consecutive cycles and r9 is accepted only once `in_ready` returns to 1.
- Simultaneous push/pop and wrap:
  - stimulus: stream 10 entries back-to-back with no stall;
  - required: `pending` stays at 1 at steady state; issue order is exact; the pointers wrap past index 3 with no loss.
- Flush priority:
  - stimulus: 2 entries queued, then `flush` and a push in the same cycle;
  - required: `pending` = 0 and `reg_write` = 0 on the next cycle, and the pushed entry is never issued.
- Forwarding (with `WB_FORWARD_EN`):
  - stimulus: queue {r3, 0x2}, then {r3, 0x7}, with `wb_stall` = 1 and `fwd_reg` = 3;
  - required: `fwd_hit` = 1 and `fwd_data` = 0x7; with `fwd_reg` = 4, `fwd_hit` = 0; without the macro, `fwd_hit` = 0 always.
